// File: rtl/lstm_cell_bwd_if.sv
// Operand/result handshake bundle for the LSTM backward cell.
// The slave modport is the cell itself; the master side supplies operands and accepts results.
interface lstm_cell_bwd_if #(
  parameter int WIDTH = 32
) ();
  logic                    i_valid;
  logic                    o_ready;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [WIDTH-1:0] i_dh;
  logic signed [WIDTH-1:0] i_dc_next;
  logic signed [WIDTH-1:0] i_a;
  logic signed [WIDTH-1:0] i_i;
  logic signed [WIDTH-1:0] i_f;
  logic signed [WIDTH-1:0] i_o;
  logic signed [WIDTH-1:0] i_c;
  logic signed [WIDTH-1:0] i_c_prev;
  logic signed [WIDTH-1:0] o_dc;
  logic signed [WIDTH-1:0] o_da;
  logic signed [WIDTH-1:0] o_di;
  logic signed [WIDTH-1:0] o_df;
  logic signed [WIDTH-1:0] o_do;
  logic signed [WIDTH-1:0] o_dc_prev;

  modport master (
    output i_valid, i_ready, i_dh, i_dc_next, i_a, i_i, i_f, i_o, i_c, i_c_prev,
    input  o_ready, o_valid, o_dc, o_da, o_di, o_df, o_do, o_dc_prev
  );

  modport slave (
    input  i_valid, i_ready, i_dh, i_dc_next, i_a, i_i, i_f, i_o, i_c, i_c_prev,
    output o_ready, o_valid, o_dc, o_da, o_di, o_df, o_do, o_dc_prev
  );
endinterface

// File: rtl/lstm_cell_bwd.sv
// LSTM cell backward pass: one shared fixed-point multiplier sequenced over 16 steps
// producing gate deltas and the cell-state gradient handed to the previous time step.
module lstm_cell_bwd #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic          clk,
  input  logic          rst,
  lstm_cell_bwd_if.slave bus
);
  localparam logic [WIDTH:0] ONE_U     = (WIDTH+1)'(1) << FRAC;
  localparam logic [WIDTH:0] HALF_U    = ONE_U >> 1;
  localparam logic [WIDTH:0] QTR_U     = ONE_U >> 2;
  localparam logic [WIDTH:0] ONEHALF_U = ONE_U + HALF_U;
  localparam logic signed [WIDTH-1:0] ONE = ONE_U[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] dh, dcn, a, i, f, o, c, cp;
  } opnd_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] dc, da, di, df, dgo, dcp;
  } outs_t;

  // Full-width product, arithmetic shift back to the fixed-point scale, wrap to WIDTH.
  function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
    p = p >>> FRAC;
    return p[WIDTH-1:0];
  endfunction

  // Piecewise-linear tanh: identity below 0.5, slope 1/2 up to 1.5, saturated at 1 beyond.
  function automatic logic signed [WIDTH-1:0] tanh_pwl(input logic signed [WIDTH-1:0] x);
    logic [WIDTH:0] mag;
    logic [WIDTH:0] y;
    mag = x[WIDTH-1] ? (~{1'b1, x} + (WIDTH+1)'(1)) : {1'b0, x};
    if (mag <= HALF_U)         y = mag;
    else if (mag <= ONEHALF_U) y = (mag >> 1) + QTR_U;
    else                       y = ONE_U;
    if (x[WIDTH-1]) return -$signed(y[WIDTH-1:0]);
    else            return $signed(y[WIDTH-1:0]);
  endfunction

  state_t                  state_q, state_d;
  logic [3:0]              step_q, step_d;
  opnd_t                   ops_q, ops_d;
  outs_t                   outs_q, outs_d;
  logic signed [WIDTH-1:0] res_q [16];
  logic signed [WIDTH-1:0] res_d [16];
  logic signed [WIDTH-1:0] t_val, mul_a, mul_b, addend, result;

  assign t_val = tanh_pwl(ops_q.c);

  // Step schedule; res_q[n] holds the value produced by step n.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    addend = '0;
    case (step_q)
      4'd0:  begin mul_a = t_val;     mul_b = t_val;             end
      4'd1:  begin mul_a = ops_q.dh;  mul_b = ops_q.o;           end
      4'd2:  begin mul_a = res_q[1];  mul_b = ONE - res_q[0]; addend = ops_q.dcn; end
      4'd3:  begin mul_a = res_q[2];  mul_b = ops_q.i;           end
      4'd4:  begin mul_a = ops_q.a;   mul_b = ops_q.a;           end
      4'd5:  begin mul_a = res_q[3];  mul_b = ONE - res_q[4];    end
      4'd6:  begin mul_a = res_q[2];  mul_b = ops_q.a;           end
      4'd7:  begin mul_a = ops_q.i;   mul_b = ONE - ops_q.i;     end
      4'd8:  begin mul_a = res_q[6];  mul_b = res_q[7];          end
      4'd9:  begin mul_a = res_q[2];  mul_b = ops_q.cp;          end
      4'd10: begin mul_a = ops_q.f;   mul_b = ONE - ops_q.f;     end
      4'd11: begin mul_a = res_q[9];  mul_b = res_q[10];         end
      4'd12: begin mul_a = ops_q.dh;  mul_b = t_val;             end
      4'd13: begin mul_a = ops_q.o;   mul_b = ONE - ops_q.o;     end
      4'd14: begin mul_a = res_q[12]; mul_b = res_q[13];         end
      default: begin mul_a = res_q[2]; mul_b = ops_q.f;          end
    endcase
    result = fx_mul(mul_a, mul_b) + addend;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ops_d   = ops_q;
    outs_d  = outs_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          ops_d.dh  = bus.i_dh;
          ops_d.dcn = bus.i_dc_next;
          ops_d.a   = bus.i_a;
          ops_d.i   = bus.i_i;
          ops_d.f   = bus.i_f;
          ops_d.o   = bus.i_o;
          ops_d.c   = bus.i_c;
          ops_d.cp  = bus.i_c_prev;
          step_d    = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        res_d[step_q] = result;
        step_d        = step_q + 4'd1;
        if (step_q == 4'd15) begin
          state_d     = DONE;
          outs_d.dc   = res_q[2];
          outs_d.da   = res_q[5];
          outs_d.di   = res_q[8];
          outs_d.df   = res_q[11];
          outs_d.dgo  = res_q[14];
          outs_d.dcp  = result;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      ops_q   <= '0;
      outs_q  <= '0;
      res_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ops_q   <= ops_d;
      outs_q  <= outs_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_ready   = (state_q == IDLE);
  assign bus.o_valid   = (state_q == DONE);
  assign bus.o_dc      = outs_q.dc;
  assign bus.o_da      = outs_q.da;
  assign bus.o_di      = outs_q.di;
  assign bus.o_df      = outs_q.df;
  assign bus.o_do      = outs_q.dgo;
  assign bus.o_dc_prev = outs_q.dcp;
endmodule
